// File: rtl/fnd_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment display path: segment codes,
// blank patterns, slot indices and the decimal-point mask.
package fnd_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [5:0] COM_OFF  = 6'h3F;

  // Active-low {g,f,e,d,c,b,a} codes for BCD 0..9.
  localparam logic [0:9][6:0] SEG_TBL = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [2:0] IDX_MS0 = 3'd0;
  localparam logic [2:0] IDX_MS1 = 3'd1;
  localparam logic [2:0] IDX_S0  = 3'd2;
  localparam logic [2:0] IDX_S1  = 3'd3;
  localparam logic [2:0] IDX_M0  = 3'd4;
  localparam logic [2:0] IDX_M1  = 3'd5;

  // dp follows the units digit of seconds and minutes: mm.ss.cc
  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/fnd_scan_driver_if.sv
// Digit inputs and display outputs of the scan driver; master is the
// upstream time counter, slave is the driver.
interface fnd_scan_driver_if;
  logic       i_en;
  logic       i_lz_blank;
  logic [3:0] i_ms0, i_ms1, i_s0, i_s1, i_m0, i_m1;
  logic [6:0] o_seg_n;
  logic       o_dp_n;
  logic [5:0] o_com_n;
  logic       o_frame_tick;

  modport master (
    output i_en, i_lz_blank, i_ms0, i_ms1, i_s0, i_s1, i_m0, i_m1,
    input  o_seg_n, o_dp_n, o_com_n, o_frame_tick
  );
  modport slave (
    input  i_en, i_lz_blank, i_ms0, i_ms1, i_s0, i_s1, i_m0, i_m1,
    output o_seg_n, o_dp_n, o_com_n, o_frame_tick
  );
endinterface

// File: rtl/fnd_scan_driver_bcd_to_seg7.sv
// BCD to active-low 7-segment decode; codes A..F show a dash.
module bcd_to_seg7
  import fnd_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = SEG_DASH;
    if (bcd <= 4'd9) seg_n = SEG_TBL[bcd];
  end
endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 6-digit common-anode driver: prescaler, slot sequencer,
// per-frame digit snapshot and registered segment/common outputs.
module fnd_scan_driver
  import fnd_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  fnd_scan_driver_if.slave bus
);
  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [5:0][3:0] snap, snap_eff, din;
  logic            load, wrap, lz_hide;
  logic [3:0]      digit;
  logic [6:0]      dec_seg;

  assign din  = {bus.i_m1, bus.i_m0, bus.i_s1, bus.i_s0, bus.i_ms1, bus.i_ms0};
  assign load = bus.i_en && (cnt == '0) && (idx == IDX_MS0);
  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  // The digits loaded this cycle are what the new frame shows, so slot 0's
  // blank window already carries the fresh value.
  assign snap_eff = load ? din : snap;
  assign digit    = snap_eff[idx];

  assign lz_hide = bus.i_lz_blank && (snap_eff[IDX_M1] == 4'd0) &&
                   ((idx == IDX_M1) || ((idx == IDX_M0) && (snap_eff[IDX_M0] == 4'd0)));

  bcd_to_seg7 u_dec (.bcd(digit), .seg_n(dec_seg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      idx              <= IDX_MS0;
      snap             <= '0;
      bus.o_seg_n      <= SEG_OFF;
      bus.o_dp_n       <= 1'b1;
      bus.o_com_n      <= COM_OFF;
      bus.o_frame_tick <= 1'b0;
    end else if (!bus.i_en) begin
      cnt              <= '0;
      idx              <= IDX_MS0;
      bus.o_seg_n      <= SEG_OFF;
      bus.o_dp_n       <= 1'b1;
      bus.o_com_n      <= COM_OFF;
      bus.o_frame_tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= (idx == IDX_M1) ? IDX_MS0 : idx + 3'd1;
      if (load) snap <= din;
      bus.o_frame_tick <= load;
      bus.o_seg_n      <= lz_hide ? SEG_OFF : dec_seg;
      bus.o_dp_n       <= ~(DP_MASK[idx] && !lz_hide);
      bus.o_com_n      <= (cnt >= CW'(BLANK_CYC)) ? (COM_OFF & ~(6'd1 << idx)) : COM_OFF;
    end
  end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized bench for fnd_scan_driver against a time-based display model.
module tb_fnd_scan_driver;
  localparam int SD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_driver_if bus();
  fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [3:0] dig  [6];
  logic [3:0] snap [6];
  int         t;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_tick;
  logic [5:0] exp_com;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.i_ms0 = dig[0]; bus.i_ms1 = dig[1]; bus.i_s0 = dig[2];
    bus.i_s1  = dig[3]; bus.i_m0  = dig[4]; bus.i_m1 = dig[5];
  endtask

  task automatic set_off();
    exp_seg = 7'h7F; exp_dp = 1'b1; exp_com = 6'h3F; exp_tick = 1'b0;
  endtask

  task automatic check_outs(input string ph);
    chk({ph, "_seg"},  bus.o_seg_n, exp_seg);
    chk({ph, "_dp"},   bus.o_dp_n, exp_dp);
    chk({ph, "_com"},  bus.o_com_n, exp_com);
    chk({ph, "_tick"}, bus.o_frame_tick, exp_tick);
  endtask

  // Expected outputs after the coming edge, from elapsed enabled time alone.
  task automatic step_model();
    int slot, pos;
    bit hide;
    if (!bus.i_en) begin
      set_off();
      t = 0;
    end else begin
      slot = (t / SD) % 6;
      pos  = t % SD;
      exp_tick = (t % (6 * SD)) == 0;
      if (exp_tick) for (int k = 0; k < 6; k++) snap[k] = dig[k];
      hide = bus.i_lz_blank && snap[5] == 0 && (slot == 5 || (slot == 4 && snap[4] == 0));
      exp_seg = hide ? 7'h7F : seg_ref[snap[slot]];
      exp_dp  = !((slot == 2 || slot == 4) && !hide);
      exp_com = (pos >= BC) ? ~(6'(1) << slot) : 6'h3F;
      t++;
    end
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 6; k++) begin dig[k] = 4'(k + 1); snap[k] = 4'd0; end
    bus.i_en = 1'b0; bus.i_lz_blank = 1'b0;
    drive();
    t = 0;
    set_off();
    repeat (3) @(negedge clk);
    check_outs("reset");
    rst_n = 1'b1;
    bus.i_en = 1'b1;
    step_model();
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_outs("run");
      chk("com_onehot", 32'($countones(~bus.o_com_n) <= 1), 32'd1);
      // directed scenarios, then random
      case (cyc)
        75:  dig[2] = 4'd9;
        150: begin bus.i_lz_blank = 1'b1; dig[5] = 4'd0; dig[4] = 4'd0; end
        250: dig[4] = 4'd7;
        350: dig[0] = 4'hC;
        420: bus.i_en = 1'b0;
        423: bus.i_en = 1'b1;
        default: ;
      endcase
      if (cyc == 400 || (cyc > 500 && $urandom_range(0, 299) == 0)) begin
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) snap[k] = 4'd0;
        t = 0;
        set_off();
        check_outs("rst_async");
        repeat (2) begin @(negedge clk); check_outs("rst_hold"); end
        rst_n = 1'b1;
      end
      if (cyc > 500) begin
        if ($urandom_range(0, 5) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 99) == 0) bus.i_lz_blank = ~bus.i_lz_blank;
        if ($urandom_range(0, 39) == 0) begin dig[5] = 4'd0; dig[4] = 4'($urandom_range(0, 1)); end
        if (bus.i_en) begin if ($urandom_range(0, 199) == 0) bus.i_en = 1'b0; end
        else if ($urandom_range(0, 3) == 0) bus.i_en = 1'b1;
      end
      drive();
      step_model();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
